// File: rtl/decoder_pkg.sv
// Shared types and constants for the registered 2-to-4 decoder with output hold.
package decoder_pkg;

  localparam int unsigned CODE_W = 2;
  localparam int unsigned LINES  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Hold counter width: ceil(log2(hold_cycles)), never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned hold_cycles);
    return (hold_cycles <= 2) ? 1 : $clog2(hold_cycles);
  endfunction

endpackage

// File: rtl/decoder_2to4_hold_if.sv
// Handshake, control and decoded-output bundle of decoder_2to4_hold.
interface decoder_2to4_hold_if;

  logic                              in_valid;
  logic                              in_ready;
  logic [decoder_pkg::CODE_W-1:0]    code;
  logic                              flush;
  logic [decoder_pkg::LINES-1:0]     dec_out;
  logic                              out_valid;
  logic                              done;

  modport master (
    output in_valid, code, flush,
    input  in_ready, dec_out, out_valid, done
  );

  modport slave (
    input  in_valid, code, flush,
    output in_ready, dec_out, out_valid, done
  );

endinterface

// File: rtl/hold_timer.sv
// Load / decrement down-counter with zero flag; saturates at zero.
module hold_timer
  import decoder_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  input  logic clr,
  output logic zero
);

  localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = CNT_W'(HOLD_CYCLES - 1);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/decoder_2to4_hold.sv
// Registered 2-to-4 one-hot decoder: accepts one code, holds the line for
// HOLD_CYCLES cycles, then pulses done. Back-pressures new codes while holding.
module decoder_2to4_hold
  import decoder_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decoder_2to4_hold_if.slave   bus
);

  state_e             state_q;
  state_e             state_d;
  logic [LINES-1:0]   dec_out_q;
  logic [LINES-1:0]   dec_out_d;
  logic               out_valid_q;
  logic               out_valid_d;
  logic               done_q;
  logic               done_d;

  logic               tmr_load;
  logic               tmr_dec;
  logic               tmr_clr;
  logic               tmr_zero;

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tmr_load),
    .dec   (tmr_dec),
    .clr   (tmr_clr),
    .zero  (tmr_zero)
  );

  always_comb begin
    state_d     = state_q;
    dec_out_d   = dec_out_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;
    tmr_clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // flush is meaningless here; an accept always wins.
        if (bus.in_valid) begin
          state_d     = HOLD;
          dec_out_d   = LINES'(1) << bus.code;
          out_valid_d = 1'b1;
          tmr_load    = 1'b1;
        end
      end
      HOLD: begin
        if (bus.flush) begin
          state_d     = IDLE;
          dec_out_d   = '0;
          out_valid_d = 1'b0;
          tmr_clr     = 1'b1;
        end else if (tmr_zero) begin
          state_d     = IDLE;
          dec_out_d   = '0;
          out_valid_d = 1'b0;
          done_d      = 1'b1;
        end else begin
          tmr_dec     = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        dec_out_d   = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dec_out_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dec_out_q   <= dec_out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.dec_out   = dec_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_decoder_2to4_hold.sv
// Self-checking bench: two decoders (hold 4 and hold 1) share stimulus and are
// compared every cycle against a remaining-cycles reference model.
module tb_decoder_2to4_hold;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] code = 2'b00;
  logic       flush = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  decoder_2to4_hold_if ifa ();
  decoder_2to4_hold_if ifb ();

  assign ifa.in_valid = in_valid;
  assign ifa.code     = code;
  assign ifa.flush    = flush;
  assign ifb.in_valid = in_valid;
  assign ifb.code     = code;
  assign ifb.flush    = flush;

  decoder_2to4_hold #(.HOLD_CYCLES(4)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  decoder_2to4_hold #(.HOLD_CYCLES(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: cycles of output still to be shown after the last edge.
  int         hold_len [2] = '{4, 1};
  int         left     [2];
  logic [3:0] m_line   [2];
  logic       m_done   [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        left[i]   = 0;
        m_line[i] = 4'b0000;
        m_done[i] = 1'b0;
      end else if (left[i] == 0) begin
        m_done[i] = 1'b0;
        if (in_valid) begin
          left[i]   = hold_len[i];
          m_line[i] = 4'b0001 << code;
        end
      end else if (flush) begin
        left[i]   = 0;
        m_line[i] = 4'b0000;
        m_done[i] = 1'b0;
      end else begin
        left[i] = left[i] - 1;
        if (left[i] == 0) begin
          m_line[i] = 4'b0000;
          m_done[i] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check_eq("a_dec_out",   32'(ifa.dec_out),   32'(m_line[0]));
    check_eq("a_out_valid", 32'(ifa.out_valid), 32'(m_line[0] != 4'b0000));
    check_eq("a_done",      32'(ifa.done),      32'(m_done[0]));
    check_eq("a_in_ready",  32'(ifa.in_ready),  32'(left[0] == 0));
    check_eq("b_dec_out",   32'(ifb.dec_out),   32'(m_line[1]));
    check_eq("b_out_valid", 32'(ifb.out_valid), 32'(m_line[1] != 4'b0000));
    check_eq("b_done",      32'(ifb.done),      32'(m_done[1]));
    check_eq("b_in_ready",  32'(ifb.in_ready),  32'(left[1] == 0));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int seen_done;
    int cnt;

    repeat (3) @(negedge clk);
    check_eq("rst_ready_low", 32'(ifa.in_ready), 32'd1);
    check_eq("rst_dec_low",   32'(ifa.dec_out),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_dec",   32'(ifa.dec_out),   32'd0);
    check_eq("post_rst_valid", 32'(ifa.out_valid), 32'd0);
    check_eq("post_rst_done",  32'(ifa.done),      32'd0);
    check_eq("post_rst_ready", 32'(ifa.in_ready),  32'd1);

    // One code at a time, waiting for done on the hold-4 instance.
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      code     = 2'(c);
      @(negedge clk);
      in_valid = 1'b0;
      hi = 0;
      seen_done = 0;
      for (int k = 0; k < 30; k++) begin
        if (ifa.done) begin
          seen_done = 1;
          break;
        end
        if (ifa.out_valid) begin
          hi++;
          check_eq("seq_line",  32'(ifa.dec_out),  32'(4'b0001 << c));
          check_eq("seq_ready", 32'(ifa.in_ready), 32'd0);
        end
        @(negedge clk);
      end
      check_eq("seq_done_seen", 32'(seen_done), 32'd1);
      check_eq("seq_hold_len",  32'(hi),        32'd4);
      check_eq("seq_done_ready", 32'(ifa.in_ready), 32'd1);
    end
    repeat (3) @(negedge clk);

    // in_valid held high with code 10 for 12 edges.
    in_valid = 1'b1;
    code     = 2'b10;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (ifa.dec_out == 4'b0100) cnt++;
    end
    in_valid = 1'b0;
    check_eq("stream_active_cycles", 32'(cnt), 32'd10);
    repeat (6) @(negedge clk);

    // Code change during hold is ignored.
    in_valid = 1'b1;
    code     = 2'b11;
    @(negedge clk);
    code = 2'b00;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("code_ignored", 32'(ifa.dec_out), 32'h8);
    repeat (6) @(negedge clk);

    // Flush on the second hold cycle.
    in_valid = 1'b1;
    code     = 2'b01;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_dec",   32'(ifa.dec_out),  32'd0);
    check_eq("flush_done",  32'(ifa.done),     32'd0);
    check_eq("flush_ready", 32'(ifa.in_ready), 32'd1);
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of a hold.
    in_valid = 1'b1;
    code     = 2'b10;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_dec",   32'(ifa.dec_out),   32'd0);
    check_eq("async_rst_valid", 32'(ifa.out_valid), 32'd0);
    check_eq("async_rst_done",  32'(ifa.done),      32'd0);
    check_eq("async_rst_ready", 32'(ifa.in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Randomized traffic, checked cycle by cycle against the model.
    for (int k = 0; k < 400; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      code     = 2'($urandom_range(0, 3));
      flush    = ($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (8) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
